// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared types and constants for the CSR execution unit
package csr_pkg;

    localparam int CSR_XLEN        = 32;
    localparam int CSR_NCSR        = 6;
    localparam int CSR_ECALL_CAUSE = 11;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    localparam logic [2:0] IDX_MSTATUS  = 3'd0;
    localparam logic [2:0] IDX_MEPC     = 3'd1;
    localparam logic [2:0] IDX_MCAUSE   = 3'd2;
    localparam logic [2:0] IDX_MSCRATCH = 3'd3;
    localparam logic [2:0] IDX_MTVAL    = 3'd4;
    localparam logic [2:0] IDX_MTVEC    = 3'd5;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/csr_addr_decode.sv
// rtl/csr_addr_decode.sv - maps a 12-bit CSR address onto a CSR file index
module csr_addr_decode
    import csr_pkg::*;
(
    input  logic [11:0] addr_i,
    output logic [2:0]  idx_o,
    output logic        hit_o
);

    always_comb begin
        idx_o = IDX_MSTATUS;
        hit_o = 1'b1;
        unique case (addr_i)
            ADDR_MSTATUS:  idx_o = IDX_MSTATUS;
            ADDR_MEPC:     idx_o = IDX_MEPC;
            ADDR_MCAUSE:   idx_o = IDX_MCAUSE;
            ADDR_MSCRATCH: idx_o = IDX_MSCRATCH;
            ADDR_MTVAL:    idx_o = IDX_MTVAL;
            ADDR_MTVEC:    idx_o = IDX_MTVEC;
            default:       hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_exec_unit.sv
// rtl/csr_exec_unit.sv - Zicsr/ECALL/MRET execute stage driving a 6-entry CSR file
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter int XLEN        = CSR_XLEN,
    parameter int NCSR        = CSR_NCSR,
    parameter int ECALL_CAUSE = CSR_ECALL_CAUSE
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [2:0]                 in_op_i,
    input  logic                       in_imm_i,
    input  logic [4:0]                 in_rs1_idx_i,
    input  logic [XLEN-1:0]            in_src_i,
    input  logic [11:0]                in_csr_addr_i,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic [NCSR-1:0][XLEN-1:0]  csr_rdata_i,
    output logic [NCSR-1:0]            csr_wen_o,
    output logic [NCSR-1:0][XLEN-1:0]  csr_wdata_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [XLEN-1:0]            out_rd_val_o,
    output logic                       out_redirect_o,
    output logic [XLEN-1:0]            out_redirect_pc_o,
    output logic                       out_illegal_o
);

    state_e state_q, state_d;

    logic [2:0]      op_q;
    logic            imm_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] src_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] pc_q;

    logic [XLEN-1:0] rd_val_q, rd_val_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            illegal_q, illegal_d;

    logic [2:0]                dec_idx;
    logic                      dec_hit;
    logic [XLEN-1:0]           operand;
    logic [XLEN-1:0]           old_val;
    logic [XLEN-1:0]           mstatus_new;
    logic [NCSR-1:0]           wen_c;
    logic [NCSR-1:0][XLEN-1:0] wdata_c;

    csr_addr_decode u_decode (
        .addr_i (addr_q),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid_i) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (out_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q          <= '0;
            imm_q         <= 1'b0;
            rs1_idx_q     <= '0;
            src_q         <= '0;
            addr_q        <= '0;
            pc_q          <= '0;
            rd_val_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_valid_i) begin
                op_q      <= in_op_i;
                imm_q     <= in_imm_i;
                rs1_idx_q <= in_rs1_idx_i;
                src_q     <= in_src_i;
                addr_q    <= in_csr_addr_i;
                pc_q      <= in_pc_i;
            end
            if (state_q == ST_EXEC) begin
                rd_val_q      <= rd_val_d;
                redirect_q    <= redirect_d;
                redirect_pc_q <= redirect_pc_d;
                illegal_q     <= illegal_d;
            end
        end
    end

    always_comb begin
        wen_c         = '0;
        wdata_c       = '0;
        rd_val_d      = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        illegal_d     = 1'b0;
        old_val       = '0;
        mstatus_new   = csr_rdata_i[IDX_MSTATUS];
        operand       = imm_q ? {{(XLEN-5){1'b0}}, rs1_idx_q} : src_q;

        for (int i = 0; i < NCSR; i++) begin
            if (dec_idx == 3'(i)) old_val = csr_rdata_i[i];
        end

        unique case (op_q)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                if (!dec_hit) begin
                    illegal_d = 1'b1;
                end else begin
                    rd_val_d = old_val;
                    for (int i = 0; i < NCSR; i++) begin
                        if (dec_idx == 3'(i)) begin
                            // Set/clear with rs1=x0 is a pure read and must not write.
                            wen_c[i] = (op_q == OP_CSRRW) || (rs1_idx_q != 5'd0);
                            if (op_q == OP_CSRRW)      wdata_c[i] = operand;
                            else if (op_q == OP_CSRRS) wdata_c[i] = old_val | operand;
                            else                       wdata_c[i] = old_val & ~operand;
                        end
                    end
                end
            end
            OP_ECALL: begin
                mstatus_new[MSTATUS_MPIE] = csr_rdata_i[IDX_MSTATUS][MSTATUS_MIE];
                mstatus_new[MSTATUS_MIE]  = 1'b0;
                mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                wen_c[IDX_MSTATUS]   = 1'b1;
                wen_c[IDX_MEPC]      = 1'b1;
                wen_c[IDX_MCAUSE]    = 1'b1;
                wdata_c[IDX_MSTATUS] = mstatus_new;
                wdata_c[IDX_MEPC]    = pc_q;
                wdata_c[IDX_MCAUSE]  = XLEN'(ECALL_CAUSE);
                redirect_d    = 1'b1;
                redirect_pc_d = {csr_rdata_i[IDX_MTVEC][XLEN-1:2], 2'b00};
            end
            OP_MRET: begin
                mstatus_new[MSTATUS_MIE]  = csr_rdata_i[IDX_MSTATUS][MSTATUS_MPIE];
                mstatus_new[MSTATUS_MPIE] = 1'b1;
                mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                wen_c[IDX_MSTATUS]   = 1'b1;
                wdata_c[IDX_MSTATUS] = mstatus_new;
                redirect_d    = 1'b1;
                redirect_pc_d = csr_rdata_i[IDX_MEPC];
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // rst is folded in combinationally so a reset during EXEC kills the write that cycle.
    always_comb begin
        csr_wen_o   = '0;
        csr_wdata_o = '0;
        if (state_q == ST_EXEC && !rst_i) begin
            csr_wen_o = wen_c;
            for (int i = 0; i < NCSR; i++) begin
                if (wen_c[i]) csr_wdata_o[i] = wdata_c[i];
            end
        end
    end

    assign in_ready_o        = (state_q == ST_IDLE);
    assign out_valid_o       = (state_q == ST_RESP);
    assign out_rd_val_o      = rd_val_q;
    assign out_redirect_o    = redirect_q;
    assign out_redirect_pc_o = redirect_pc_q;
    assign out_illegal_o     = illegal_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// tb/tb_csr_exec_unit.sv - randomized self-checking bench with a behavioural CSR model
module tb_csr_exec_unit;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic              in_imm;
    logic [4:0]        in_rs1_idx;
    logic [31:0]       in_src;
    logic [11:0]       in_csr_addr;
    logic [31:0]       in_pc;
    logic [5:0][31:0]  csr_mem;
    logic [5:0]        csr_wen;
    logic [5:0][31:0]  csr_wdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rd_val;
    logic              out_redirect;
    logic [31:0]       out_redirect_pc;
    logic              out_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_exec_unit dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .in_op_i           (in_op),
        .in_imm_i          (in_imm),
        .in_rs1_idx_i      (in_rs1_idx),
        .in_src_i          (in_src),
        .in_csr_addr_i     (in_csr_addr),
        .in_pc_i           (in_pc),
        .csr_rdata_i       (csr_mem),
        .csr_wen_o         (csr_wen),
        .csr_wdata_o       (csr_wdata),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_rd_val_o      (out_rd_val),
        .out_redirect_o    (out_redirect),
        .out_redirect_pc_o (out_redirect_pc),
        .out_illegal_o     (out_illegal)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference semantics computed from the architectural rules on the bench's CSR image.
    task automatic model(input logic [2:0] op, input logic imm, input logic [4:0] rs1,
                         input logic [31:0] src, input logic [11:0] addr, input logic [31:0] pc,
                         output logic [5:0] wen, output logic [5:0][31:0] wd,
                         output logic [31:0] rd, output logic redir,
                         output logic [31:0] rpc, output logic ill);
        int idx;
        logic [31:0] opnd, ms, bit_v;
        wen = '0; wd = '0; rd = 0; redir = 0; rpc = 0; ill = 0;
        case (addr)
            12'h300: idx = 0;
            12'h341: idx = 1;
            12'h342: idx = 2;
            12'h340: idx = 3;
            12'h343: idx = 4;
            12'h305: idx = 5;
            default: idx = -1;
        endcase
        opnd = imm ? 32'(rs1) : src;
        ms = csr_mem[0];
        case (op)
            3'd0, 3'd1, 3'd2: begin
                if (idx < 0) begin
                    ill = 1;
                end else begin
                    rd = csr_mem[idx];
                    if (op == 3'd0 || rs1 != 0) begin
                        wen[idx] = 1'b1;
                        if (op == 3'd0)      wd[idx] = opnd;
                        else if (op == 3'd1) wd[idx] = csr_mem[idx] | opnd;
                        else                 wd[idx] = csr_mem[idx] & ~opnd;
                    end
                end
            end
            3'd4: begin
                bit_v = (ms >> 3) & 1;
                wen = 6'b000111;
                wd[0] = (ms & ~32'h1888) | (bit_v << 7) | 32'h1800;
                wd[1] = pc;
                wd[2] = 11;
                redir = 1;
                rpc = csr_mem[5] - (csr_mem[5] % 4);
            end
            3'd5: begin
                bit_v = (ms >> 7) & 1;
                wen = 6'b000001;
                wd[0] = (ms & ~32'h1888) | (bit_v << 3) | 32'h0080 | 32'h1800;
                redir = 1;
                rpc = csr_mem[1];
            end
            default: ill = 1;
        endcase
    endtask

    task automatic run_instr(input logic [2:0] op, input logic imm, input logic [4:0] rs1,
                             input logic [31:0] src, input logic [11:0] addr,
                             input logic [31:0] pc, input int hold);
        logic [5:0]       e_wen;
        logic [5:0][31:0] e_wd;
        logic [31:0]      e_rd, e_rpc;
        logic             e_redir, e_ill;
        logic [5:0]       s_wen;
        logic [5:0][31:0] s_wd;
        @(negedge clk);
        check_val("accept_ready", 32'(in_ready), 1);
        in_valid = 1; in_op = op; in_imm = imm; in_rs1_idx = rs1;
        in_src = src; in_csr_addr = addr; in_pc = pc;
        @(negedge clk);
        in_valid = 0;
        in_src = $urandom; in_csr_addr = 12'($urandom); in_rs1_idx = 5'($urandom);
        model(op, imm, rs1, src, addr, pc, e_wen, e_wd, e_rd, e_redir, e_rpc, e_ill);
        s_wen = csr_wen;
        s_wd = csr_wdata;
        check_val("exec_wen", 32'(csr_wen), 32'(e_wen));
        for (int i = 0; i < 6; i++)
            check_val($sformatf("exec_wdata%0d", i), csr_wdata[i], e_wd[i]);
        check_val("exec_ready", 32'(in_ready), 0);
        check_val("exec_valid", 32'(out_valid), 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++)
            if (s_wen[i]) csr_mem[i] = s_wd[i];
        check_val("resp_wen", 32'(csr_wen), 0);
        for (int h = 0; h <= hold; h++) begin
            check_val("resp_valid", 32'(out_valid), 1);
            check_val("resp_ready", 32'(in_ready), 0);
            check_val("resp_rd", out_rd_val, e_rd);
            check_val("resp_redir", 32'(out_redirect), 32'(e_redir));
            check_val("resp_rpc", out_redirect_pc, e_rpc);
            check_val("resp_ill", 32'(out_illegal), 32'(e_ill));
            if (h < hold) @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check_val("back_idle_ready", 32'(in_ready), 1);
        check_val("back_idle_valid", 32'(out_valid), 0);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [11:0] r_addr;
        logic [11:0] addrs [6];
        addrs[0] = 12'h300; addrs[1] = 12'h341; addrs[2] = 12'h342;
        addrs[3] = 12'h340; addrs[4] = 12'h343; addrs[5] = 12'h305;

        rst = 1; in_valid = 0; out_ready = 0; in_op = 0; in_imm = 0;
        in_rs1_idx = 0; in_src = 0; in_csr_addr = 0; in_pc = 0;
        csr_mem[0] = 32'h0000_1888; csr_mem[1] = 32'h0; csr_mem[2] = 32'h0;
        csr_mem[3] = 32'h1234_5678; csr_mem[4] = 32'h0; csr_mem[5] = 32'h0000_0200;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(in_ready), 1);
        check_val("rst_valid", 32'(out_valid), 0);
        check_val("rst_wen", 32'(csr_wen), 0);
        check_val("rst_wdata0", csr_wdata[0], 0);
        check_val("rst_redir", 32'(out_redirect), 0);
        check_val("rst_ill", 32'(out_illegal), 0);
        check_val("rst_rd", out_rd_val, 0);
        check_val("rst_rpc", out_redirect_pc, 0);
        rst = 0;

        run_instr(3'd0, 0, 5'd5, 32'h8000_0100, 12'h305, 32'h0, 0);
        check_val("mtvec_written", csr_mem[5], 32'h8000_0100);
        csr_mem[0] = 32'h0000_1888;
        run_instr(3'd1, 0, 5'd0, 32'hFFFF_FFFF, 12'h300, 32'h0, 0);
        run_instr(3'd1, 1, 5'd8, 32'h0, 12'h300, 32'h0, 0);
        csr_mem[0] = 32'h0000_0008; csr_mem[5] = 32'h8000_0103;
        run_instr(3'd4, 0, 5'd0, 32'h0, 12'h000, 32'h8000_0040, 0);
        check_val("ecall_mstatus", csr_mem[0], 32'h0000_1880);
        check_val("ecall_mcause", csr_mem[2], 32'd11);
        csr_mem[1] = 32'h8000_0044;
        run_instr(3'd5, 0, 5'd0, 32'h0, 12'h000, 32'h0, 0);
        check_val("mret_mstatus", csr_mem[0], 32'h0000_1888);
        run_instr(3'd0, 0, 5'd3, 32'hDEAD_BEEF, 12'h7C0, 32'h0, 5);
        run_instr(3'd3, 0, 5'd3, 32'h1, 12'h300, 32'h0, 1);

        // Reset landing on the EXEC cycle must kill the pending write.
        @(negedge clk);
        in_valid = 1; in_op = 3'd0; in_imm = 0; in_rs1_idx = 5'd1;
        in_src = 32'hCAFE_F00D; in_csr_addr = 12'h340;
        @(negedge clk);
        in_valid = 0; rst = 1;
        #1;
        check_val("rstexec_wen", 32'(csr_wen), 0);
        @(negedge clk);
        rst = 0;
        check_val("rstexec_ready", 32'(in_ready), 1);
        check_val("rstexec_valid", 32'(out_valid), 0);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: r_op = 3'd0;
                3, 4:    r_op = 3'd1;
                5, 6:    r_op = 3'd2;
                7:       r_op = 3'd4;
                8:       r_op = 3'd5;
                default: r_op = 3'($urandom);
            endcase
            r_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 5)];
            run_instr(r_op, 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                      $urandom, r_addr, $urandom, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
